// File: rtl/fp_sqrt_norm_round.sv
// Normalize-and-round stage behind the FP sqrt mantissa divider: left-shifts the raw
// quotient one bit per cycle until its MSB is set, then rounds to MW fraction bits.
module fp_sqrt_norm_round #(
   parameter int QW = 255,
   parameter int MW = 23,
   parameter int EW = 12
) (
   input  logic          in_Clk,
   input  logic          in_Rst,
   input  logic          in_start,
   input  logic [QW-1:0] in_quot,
   input  logic [EW-1:0] in_exp,
   input  logic          in_sign,
   input  logic [2:0]    in_rm,
   output logic          out_stall,
   output logic          out_valid,
   output logic [MW-1:0] out_mant,
   output logic [EW-1:0] out_exp,
   output logic          out_zero,
   output logic          out_inexact
);

   typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

   state_t        state;
   logic [QW-1:0] q;
   logic [EW-1:0] e;
   logic          sign;
   logic [2:0]    rm;

   logic [MW:0]   kept;
   logic          guard;
   logic          sticky;
   logic          inc;
   logic [MW+1:0] sum;

   always_comb begin
      kept   = q[QW-1 -: MW+1];
      guard  = q[QW-MW-2];
      sticky = |q[QW-MW-3:0];
      case (rm)
         3'b001:  inc = 1'b0;
         3'b010:  inc = sign & (guard | sticky);
         3'b011:  inc = ~sign & (guard | sticky);
         3'b100:  inc = guard;
         default: inc = guard & (sticky | kept[0]);
      endcase
      sum = {1'b0, kept} + {{(MW+1){1'b0}}, inc};
   end

   always_ff @(posedge in_Clk) begin
      if (in_Rst) begin
         state       <= IDLE;
         q           <= '0;
         e           <= '0;
         sign        <= 1'b0;
         rm          <= '0;
         out_stall   <= 1'b0;
         out_valid   <= 1'b0;
         out_mant    <= '0;
         out_exp     <= '0;
         out_zero    <= 1'b0;
         out_inexact <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               out_valid <= 1'b0;
               if (in_start) begin
                  q         <= in_quot;
                  e         <= in_exp;
                  sign      <= in_sign;
                  rm        <= in_rm;
                  out_stall <= 1'b1;
                  state     <= NORM;
               end
            end
            NORM: begin
               if (q[QW-1] || q == '0) begin
                  state <= ROUND;
               end else begin
                  q <= q << 1;
                  e <= e - EW'(1);
               end
            end
            ROUND: begin
               out_valid <= 1'b1;
               state     <= DONE;
               if (q == '0) begin
                  out_zero    <= 1'b1;
                  out_mant    <= '0;
                  out_exp     <= '0;
                  out_inexact <= 1'b0;
               end else begin
                  out_zero    <= 1'b0;
                  out_inexact <= guard | sticky;
                  // Carry out of hidden bit: mantissa wraps to 1.0, exponent absorbs it.
                  if (sum[MW+1]) begin
                     out_mant <= '0;
                     out_exp  <= e + EW'(1);
                  end else begin
                     out_mant <= sum[MW-1:0];
                     out_exp  <= e;
                  end
               end
            end
            DONE: begin
               out_valid <= 1'b0;
               out_stall <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_sqrt_norm_round.sv
// Directed bench for fp_sqrt_norm_round with hand-computed rounding/latency vectors.
module tb_fp_sqrt_norm_round;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [254:0]  quot;
   logic [11:0]   exp_in;
   logic          sign;
   logic [2:0]    rm;
   logic          stall;
   logic          valid;
   logic [22:0]   mant;
   logic [11:0]   exp_out;
   logic          zero;
   logic          inexact;

   int vectors    = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   fp_sqrt_norm_round #(.QW(255), .MW(23), .EW(12)) dut (
      .in_Clk(clk), .in_Rst(rst), .in_start(start), .in_quot(quot), .in_exp(exp_in),
      .in_sign(sign), .in_rm(rm), .out_stall(stall), .out_valid(valid), .out_mant(mant),
      .out_exp(exp_out), .out_zero(zero), .out_inexact(inexact)
   );

   // Issues one request and waits (bounded) for out_valid; lat = edges after the start edge.
   task automatic run_op(input logic [254:0] qv, input logic [11:0] ev, input logic sv,
                         input logic [2:0] rv, output int lat, output logic valid_after);
      @(negedge clk);
      quot = qv; exp_in = ev; sign = sv; rm = rv; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = -1;
      valid_after = 1'b1;
      for (int n = 1; n <= 400; n++) begin
         @(posedge clk); #1;
         if (valid) begin
            lat = n;
            break;
         end
      end
      if (lat > 0) begin
         @(posedge clk); #1;
         valid_after = valid;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; start = 1'b0; quot = '0; exp_in = '0; sign = 1'b0; rm = '0;
      repeat (2) @(posedge clk);
      #1;
      vectors++;
      if ({stall, valid, mant, exp_out, zero, inexact} !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs got stall=%b valid=%b mant=%h exp=%h zero=%b nx=%b want all 0",
                  stall, valid, mant, exp_out, zero, inexact);
      end
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic test_basic;
      logic [254:0] v;
      v = '0; v[254] = 1'b1;
      @(negedge clk);
      quot = v; exp_in = 12'd127; sign = 1'b0; rm = 3'b000; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      vectors++;
      if (stall !== 1'b1 || valid !== 1'b0) begin
         miscompares++; $display("FAIL basic_edge0 got stall=%b valid=%b want 1 0", stall, valid);
      end
      @(posedge clk); #1;
      vectors++;
      if (stall !== 1'b1 || valid !== 1'b0) begin
         miscompares++; $display("FAIL basic_edge1 got stall=%b valid=%b want 1 0", stall, valid);
      end
      @(posedge clk); #1;
      vectors++;
      if (stall !== 1'b1 || valid !== 1'b1 || mant !== 23'h0 || exp_out !== 12'd127 ||
          inexact !== 1'b0 || zero !== 1'b0) begin
         miscompares++;
         $display("FAIL basic_edge2 got stall=%b valid=%b mant=%h exp=%h nx=%b zero=%b want 1 1 0 07f 0 0",
                  stall, valid, mant, exp_out, inexact, zero);
      end
      @(posedge clk); #1;
      vectors++;
      if (stall !== 1'b0 || valid !== 1'b0) begin
         miscompares++; $display("FAIL basic_edge3 got stall=%b valid=%b want 0 0", stall, valid);
      end
   endtask

   task automatic test_shift;
      logic [254:0] v;
      int lat; logic va;
      v = '0; v[250] = 1'b1;
      run_op(v, 12'd127, 1'b0, 3'b000, lat, va);
      vectors++;
      if (lat != 6 || va !== 1'b0 || mant !== 23'h0 || exp_out !== 12'd123 || inexact !== 1'b0) begin
         miscompares++;
         $display("FAIL shift4 got lat=%0d pulse_after=%b mant=%h exp=%h nx=%b want 6 0 0 07b 0",
                  lat, va, mant, exp_out, inexact);
      end
      v = '0; v[0] = 1'b1;
      run_op(v, 12'd127, 1'b0, 3'b000, lat, va);
      vectors++;
      if (lat != 256 || mant !== 23'h0 || exp_out !== 12'hF81 || inexact !== 1'b0 || zero !== 1'b0) begin
         miscompares++;
         $display("FAIL shift_max got lat=%0d mant=%h exp=%h nx=%b zero=%b want 256 0 f81 0 0",
                  lat, mant, exp_out, inexact, zero);
      end
   endtask

   task automatic test_round_carry;
      logic [254:0] v;
      int lat; logic va;
      v = '0; v[254:230] = '1;
      run_op(v, 12'd127, 1'b0, 3'b000, lat, va);
      vectors++;
      if (lat != 2 || mant !== 23'h0 || exp_out !== 12'd128 || inexact !== 1'b1) begin
         miscompares++;
         $display("FAIL carry_rne got lat=%0d mant=%h exp=%h nx=%b want 2 0 080 1", lat, mant, exp_out, inexact);
      end
      run_op(v, 12'd127, 1'b0, 3'b001, lat, va);
      vectors++;
      if (mant !== 23'h7FFFFF || exp_out !== 12'd127 || inexact !== 1'b1) begin
         miscompares++;
         $display("FAIL carry_rtz got mant=%h exp=%h nx=%b want 7fffff 07f 1", mant, exp_out, inexact);
      end
   endtask

   task automatic test_ties;
      logic [254:0] tie0, tie1, stk;
      logic [2:0]   rms   [8] = '{3'b000, 3'b000, 3'b100, 3'b011, 3'b010, 3'b011, 3'b101, 3'b000};
      logic         sgns  [8] = '{1'b0,   1'b0,   1'b0,   1'b1,   1'b1,   1'b0,   1'b0,   1'b0};
      int           opsel [8] = '{0, 1, 0, 0, 0, 2, 1, 2};
      logic [22:0]  want  [8] = '{23'h0, 23'h2, 23'h1, 23'h0, 23'h1, 23'h1, 23'h2, 23'h0};
      int lat; logic va;
      tie0 = '0; tie0[254] = 1'b1; tie0[230] = 1'b1;
      tie1 = tie0; tie1[231] = 1'b1;
      stk = '0; stk[254] = 1'b1; stk[0] = 1'b1;
      for (int i = 0; i < 8; i++) begin
         run_op(opsel[i] == 0 ? tie0 : (opsel[i] == 1 ? tie1 : stk), 12'd10, sgns[i], rms[i], lat, va);
         vectors++;
         if (mant !== want[i] || exp_out !== 12'd10 || inexact !== 1'b1 || lat != 2) begin
            miscompares++;
            $display("FAIL tie_%0d rm=%b sign=%b got mant=%h exp=%h nx=%b lat=%0d want %h 00a 1 2",
                     i, rms[i], sgns[i], mant, exp_out, inexact, lat, want[i]);
         end
      end
   endtask

   task automatic test_zero;
      int lat; logic va;
      run_op('0, 12'd99, 1'b1, 3'b011, lat, va);
      vectors++;
      if (lat != 2 || zero !== 1'b1 || mant !== 23'h0 || exp_out !== 12'h0 || inexact !== 1'b0) begin
         miscompares++;
         $display("FAIL zero got lat=%0d zero=%b mant=%h exp=%h nx=%b want 2 1 0 000 0",
                  lat, zero, mant, exp_out, inexact);
      end
   endtask

   task automatic test_reset_mid_norm;
      logic [254:0] v;
      int pulses;
      v = '0; v[154] = 1'b1;
      @(negedge clk);
      quot = v; exp_in = 12'd127; sign = 1'b0; rm = 3'b000; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      vectors++;
      if (stall !== 1'b0 || valid !== 1'b0 || zero !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_mid_norm got stall=%b valid=%b zero=%b want 0 0 0", stall, valid, zero);
      end
      @(negedge clk); rst = 1'b0;
      pulses = 0;
      for (int n = 0; n < 120; n++) begin
         @(posedge clk); #1;
         if (valid || stall) pulses++;
      end
      vectors++;
      if (pulses != 0) begin
         miscompares++;
         $display("FAIL reset_no_pulse got %0d busy/valid cycles want 0", pulses);
      end
   endtask

   task automatic test_back_to_back;
      logic [254:0] a, b;
      int lat, extra;
      a = '0; a[250] = 1'b1;
      b = '1;
      @(negedge clk);
      quot = a; exp_in = 12'd127; sign = 1'b0; rm = 3'b000; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      @(negedge clk);
      quot = b; exp_in = 12'd50; sign = 1'b1; rm = 3'b001; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      lat = -1;
      for (int n = 2; n <= 40; n++) begin
         @(posedge clk); #1;
         if (valid) begin lat = n; break; end
      end
      vectors++;
      if (lat != 6 || mant !== 23'h0 || exp_out !== 12'd123 || inexact !== 1'b0) begin
         miscompares++;
         $display("FAIL busy_start got lat=%0d mant=%h exp=%h nx=%b want 6 0 07b 0", lat, mant, exp_out, inexact);
      end
      extra = 0;
      for (int n = 0; n < 20; n++) begin
         @(posedge clk); #1;
         if (valid) extra++;
      end
      vectors++;
      if (extra != 0 || stall !== 1'b0) begin
         miscompares++;
         $display("FAIL busy_no_queue got extra_pulses=%0d stall=%b want 0 0", extra, stall);
      end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_shift;
      test_round_carry;
      test_ties;
      test_zero;
      test_reset_mid_norm;
      test_back_to_back;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/fp_sqrt_norm_round.md
Name: fp_sqrt_norm_round

Overview:
Sequential normalize-and-round stage directly downstream of the FP square-root mantissa divider. It captures the wide raw quotient and shifts it left one bit per cycle until the leading one reaches the MSB, adjusting the exponent on each shift. It then rounds to MW fraction bits using the RISC-V rounding mode. It produces the packed-ready mantissa, exponent and flags for the FP sqrt result assembly.

Parameters:
QW, 255, raw quotient width (matches divider quotient output)
MW, 23, output fraction width, excluding hidden bit (23 = single, 52 = double)
EW, 12, signed exponent width (two's complement, carries guard range for under/overflow)

Ports:
in_Clk  input  1  clock, all state updates on rising edge
in_Rst  input  1  reset, synchronous, active-high
in_start  input  1  one-cycle request; operands sampled when accepted
in_quot  input  QW  raw quotient from divider; MSB position = weight 2^0 of the result
in_exp  input  EW  signed exponent that applies when in_quot[QW-1] is the leading one
in_sign  input  1  result sign; used only by RDN/RUP
in_rm  input  3  RISC-V rm: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; others treated as RNE
out_stall  output  1  high while state != IDLE
out_valid  output  1  one-cycle pulse; result outputs valid
out_mant  output  MW  rounded fraction, hidden bit removed
out_exp  output  EW  final signed exponent after normalization and round carry
out_zero  output  1  quotient was all zero
out_inexact  output  1  guard or sticky nonzero (NX flag)

Behaviour:
- Reset (in_Rst=1 at an edge): state IDLE; all outputs 0; internal regs cleared. Reset wins over every other event, including mid-NORM/ROUND.
- States:
  - IDLE: in_start=1 loads q<=in_quot, e<=in_exp, latches sign and rm -> NORM.
  - NORM: if q[QW-1]=1 or q==0 -> ROUND. Else q<=q<<1, e<=e-1, stay.
  - ROUND: registers outputs -> DONE.
  - DONE: out_valid=1 for exactly this cycle -> IDLE.
- in_start outside IDLE is ignored; no queuing.
- Latency: start sampled at edge 0 with s required shifts -> out_valid high after edge s+2. Worst case s=QW-1.
- Outputs hold their last value until the next ROUND or reset. out_valid is 0 except in DONE.
- Rounding in ROUND: kept = q[QW-1 -: MW+1] (hidden + fraction); L = kept LSB; G = q[QW-MW-2]; S = OR(q[QW-MW-3:0]).
  - Increment rule:
    - RNE: G&(S|L)
    - RTZ: 0
    - RDN: sign&(G|S)
    - RUP: ~sign&(G|S)
    - RMM: G
  - kept+inc overflowing MW+1 bits -> out_mant=0, out_exp=e+1. Else out_mant=low MW bits of sum, out_exp=e.
  - out_inexact=G|S.
- Zero: q==0 in NORM -> out_zero=1, out_mant=0, out_exp=0, out_inexact=0; no shifts performed.
- Exponent arithmetic wraps modulo 2^EW; no saturation. The upstream guarantees EW headroom.

Test Plan:
- in_quot=1<<254, in_exp=127, rm=RNE -> out_valid after edge 2; out_mant=0, out_exp=127, out_inexact=0, out_zero=0; out_stall high edges 0..2.
- in_quot=1<<250, in_exp=127 -> 4 shifts, out_valid after edge 6; out_mant=0, out_exp=123.
- in_quot bits[254:231] all 1, bit230=1, rest 0, RNE -> round carry: out_mant=0, out_exp=in_exp+1, out_inexact=1. Same operand with RTZ -> out_mant=0x7FFFFF, out_exp=in_exp, out_inexact=1.
- Tie cases (bit254=1, bit230=1, rest 0):
  - RNE with L=0 -> out_mant=0, inexact=1.
  - Set bit231 (L=1), RNE -> out_mant=2.
  - RMM on the L=0 case -> out_mant=1.
  - RUP with sign=1 -> no increment; RDN with sign=1 -> increment.
- in_quot=0 -> out_valid after edge 2, out_zero=1, out_mant=0, out_exp=0, out_inexact=0.
- Reset and busy-start handling:
  - Assert in_Rst during NORM of a 100-shift operand -> next cycle IDLE, out_stall=0, out_valid never pulses.
  - in_start pulsed while busy -> ignored; result equals the first operand only.
